// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
// Sequential InvSubBytes stage for the AES decryption datapath. A 128-bit state
// is captured, substituted LANES bytes per cycle through inverse S-boxes, and
// then presented downstream until it is accepted.
//
// Parameters:
//   LANES     : inverse S-box lanes, i.e. bytes substituted per cycle
//               (1, 2, 4, 8 or 16)
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream presents in_state
//   in_ready  : block can accept a state (IDLE)
//   in_state  : input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid : out_state holds a completed result (DONE)
//   out_ready : downstream accepts out_state
//   out_state : substituted state, same byte order as in_state
//   busy      : high while a block is in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map (rotl 1, 3, 6 xor 0x05), then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [127:0]  buf_q,   buf_d;
    logic [7:0]    sbox_in_s  [LANES];
    logic [7:0]    sbox_out_s [LANES];
    int            base_s;

    // First byte index of the group addressed by the counter.
    assign base_s = int'(cnt_q) * LANES;

    // Select the current group's bytes out of the working register.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sbox_in_s[l] = buf_q[127 - 8 * (base_s + l) -: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sbox_out_s[l] = inv_sbox(sbox_in_s[l]);
    end

    // Next-state logic for FSM, group counter and working register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d   = in_state;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    buf_d[127 - 8 * (base_s + l) -: 8] = sbox_out_s[l];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                buf_d   = 128'h0;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            buf_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign out_state = buf_q;

endmodule
